// File: rtl/watermark_scheduler.sv
// Raster-order watermark embedder: for each pixel, fetch three neighbours and a
// 2-bit watermark, form In = 2*(D3 + 2*(D2+D4)) mod 256 and embed w in its LSBs.
module watermark_scheduler #(
    parameter int IMG_W  = 3,
    parameter int IMG_H  = 3,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [7:0]        pix_rdata,
    output logic              wm_rd,
    output logic [ADDR_W-1:0] wm_addr,
    input  logic [1:0]        wm_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_mod,
    output logic [7:0]        out_wm,
    output logic [7:0]        out_row,
    output logic [7:0]        out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] COL_MAX = 8'(IMG_W - 1);
    localparam logic [7:0] ROW_MAX = 8'(IMG_H - 1);

    typedef enum logic [2:0] {IDLE, RD_D3, RD_D2, RD_D4, CAP, OUT} state_t;

    state_t      state, state_nx;
    logic [7:0]  row, col, col_nx;
    logic [7:0]  d3, d2, d4;
    logic [1:0]  w;
    logic        last_row, last_col, is_last, hs;

    function automatic logic [ADDR_W-1:0] lin_addr(input logic [7:0] r, input logic [7:0] c);
        logic [31:0] t;
        t = 32'(r) * 32'(IMG_W) + 32'(c);
        return t[ADDR_W-1:0];
    endfunction

    // Every step truncates to 8 bits, so overflow wraps rather than saturates.
    function automatic logic [7:0] mod_pix(input logic [7:0] p3, input logic [7:0] p2,
                                           input logic [7:0] p4);
        logic [7:0] a, b, c;
        a = p2 + p4;
        b = {a[6:0], 1'b0};
        c = p3 + b;
        return {c[6:0], 1'b0};
    endfunction

    assign last_row = (row == ROW_MAX);
    assign last_col = (col == COL_MAX);
    assign is_last  = last_row && last_col;
    assign col_nx   = last_col ? 8'd0 : col + 8'd1;
    assign hs       = (state == OUT) && out_ready;

    always_comb begin
        state_nx = state;
        pix_rd   = 1'b0;
        pix_addr = '0;
        wm_rd    = 1'b0;
        wm_addr  = '0;
        case (state)
            IDLE:  if (start) state_nx = RD_D3;
            RD_D3: begin
                pix_rd   = 1'b1;
                pix_addr = lin_addr(row, col_nx);
                wm_rd    = 1'b1;
                wm_addr  = lin_addr(row, col);
                state_nx = RD_D2;
            end
            // Bottom row has no row below: reads suppressed, values forced to 0 on capture.
            RD_D2: begin
                pix_rd   = !last_row;
                pix_addr = lin_addr(row + 8'd1, col);
                state_nx = RD_D4;
            end
            RD_D4: begin
                pix_rd   = !last_row;
                pix_addr = lin_addr(row + 8'd1, col_nx);
                state_nx = CAP;
            end
            CAP:   state_nx = OUT;
            OUT:   if (out_ready) state_nx = is_last ? IDLE : RD_D3;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
            col   <= '0;
            d3    <= '0;
            d2    <= '0;
            d4    <= '0;
            w     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= hs && is_last;
            case (state)
                IDLE: if (start) begin
                    row <= '0;
                    col <= '0;
                end
                RD_D2: begin
                    d3 <= pix_rdata;
                    w  <= wm_rdata;
                end
                RD_D4: d2 <= last_row ? 8'd0 : pix_rdata;
                CAP:   d4 <= last_row ? 8'd0 : pix_rdata;
                OUT: if (out_ready && !is_last) begin
                    col <= col_nx;
                    if (last_col) row <= row + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Result outputs are held at zero outside OUT so reset and idle read as all-zero.
    assign out_valid = (state == OUT);
    assign out_mod   = out_valid ? mod_pix(d3, d2, d4) : 8'd0;
    assign out_wm    = out_valid ? {out_mod[7:2], w} : 8'd0;
    assign out_row   = out_valid ? row : 8'd0;
    assign out_col   = out_valid ? col : 8'd0;
    assign out_last  = out_valid && is_last;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_watermark_scheduler.sv
// Bench for watermark_scheduler: memory models with one-cycle latency, a
// per-pixel arithmetic reference model, and directed plus randomized frames.
module tb_watermark_scheduler;

    localparam int W = 3;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk, rst_n, start;
    logic       pix_rd, wm_rd;
    logic [3:0] pix_addr, wm_addr;
    logic [7:0] pix_rdata;
    logic [1:0] wm_rdata;
    logic       out_valid, out_ready, out_last, busy, done;
    logic [7:0] out_mod, out_wm, out_row, out_col;

    int total = 0;
    int bad   = 0;

    logic [7:0] img [0:15];
    logic [1:0] wmm [0:15];
    int pix_rd_cnt = 0;
    int wm_rd_cnt  = 0;
    int done_cnt   = 0;

    watermark_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_rdata(pix_rdata),
        .wm_rd(wm_rd), .wm_addr(wm_addr), .wm_rdata(wm_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mod(out_mod), .out_wm(out_wm), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories return garbage when not read, so mistimed captures show up.
    always @(posedge clk) begin
        pix_rdata <= pix_rd ? img[pix_addr] : 8'($urandom);
        wm_rdata  <= wm_rd ? wmm[wm_addr] : 2'($urandom);
        if (pix_rd) pix_rd_cnt <= pix_rd_cnt + 1;
        if (wm_rd)  wm_rd_cnt  <= wm_rd_cnt + 1;
        if (done)   done_cnt   <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_mod(input int i, input int j);
        int jn, d3, d2, d4, a, b, c;
        jn = (j + 1) % W;
        d3 = img[i*W + jn];
        d2 = (i == H-1) ? 0 : int'(img[(i+1)*W + j]);
        d4 = (i == H-1) ? 0 : int'(img[(i+1)*W + jn]);
        a  = (d2 + d4) % 256;
        b  = (a * 2) % 256;
        c  = (d3 + b) % 256;
        return (c * 2) % 256;
    endfunction

    function automatic int exp_wm(input int i, input int j);
        return (exp_mod(i, j) / 4) * 4 + int'(wmm[i*W + j]);
    endfunction

    task automatic chk_zero(input string tag);
        chk(tag, {out_valid, out_mod, out_wm, out_row, out_col, out_last, busy, done, pix_rd, wm_rd}, 0);
    endtask

    task automatic chk_pixel(input string tag, input int i, input int j);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_mod"}, out_mod, exp_mod(i, j));
        chk({tag, "_wm"}, out_wm, exp_wm(i, j));
        chk({tag, "_row"}, out_row, i);
        chk({tag, "_col"}, out_col, j);
        chk({tag, "_last"}, out_last, (i == H-1 && j == W-1) ? 1 : 0);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_done"}, done, 0);
    endtask

    // Called on a negedge with the DUT idle (or about to start on a held start).
    task automatic run_frame(input bit rnd_ready, input bit hold, input int stall_idx, input int stall_len);
        int n, s, cyc, stall_sum, p0, w0;
        p0 = pix_rd_cnt;
        w0 = wm_rd_cnt;
        cyc = 0;
        stall_sum = 0;
        start = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (!hold) start = 1'b0;
            end while (!out_valid && n < 20);
            cyc += n;
            chk("pixel_latency", n, 5);
            chk_pixel("px", k / W, k % W);
            s = (k == stall_idx) ? stall_len : (rnd_ready ? int'($urandom_range(0, 3)) : 0);
            if (s > 0) begin
                out_ready = 1'b0;
                for (int t = 0; t < s; t++) begin
                    @(negedge clk);
                    chk_pixel("stall", k / W, k % W);
                    chk("stall_no_rd", {pix_rd, wm_rd}, 0);
                end
                out_ready = 1'b1;
                stall_sum += s;
            end
        end
        @(negedge clk);
        cyc++;
        chk("done_pulse", done, 1);
        chk("done_idle", busy, 0);
        chk("frame_cycles", cyc, 5*N + 1);
        chk("pix_rd_count", pix_rd_cnt - p0, N + 2*W*(H-1));
        chk("wm_rd_count", wm_rd_cnt - w0, N);
    endtask

    initial begin
        int n, d0;
        rst_n = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            img[a] = 8'd0;
            wmm[a] = 2'd0;
        end
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_state");

        // Reference frame I[i][j]=(i+1)(j+1) with the fixed watermark table.
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++)
                img[i*W + j] = 8'((i+1) * (j+1));
        wmm[0] = 2'd0; wmm[1] = 2'd1; wmm[2] = 2'd0;
        wmm[3] = 2'd2; wmm[4] = 2'd0; wmm[5] = 2'd0;
        wmm[6] = 2'd1; wmm[7] = 2'd0; wmm[8] = 2'd2;
        run_frame(1'b0, 1'b0, -1, 0);

        // Same frame with a 7-cycle consumer stall at pixel (1,1).
        run_frame(1'b0, 1'b0, 4, 7);

        // Saturated pixels exercise 8-bit wraparound.
        for (int a = 0; a < N; a++) begin
            img[a] = 8'd255;
            wmm[a] = 2'd0;
        end
        run_frame(1'b0, 1'b0, -1, 0);

        for (int f = 0; f < 4; f++) begin
            for (int a = 0; a < N; a++) begin
                img[a] = 8'($urandom);
                wmm[a] = 2'($urandom);
            end
            run_frame(1'b1, 1'b0, -1, 0);
        end

        // start held through a frame: ignored while busy, restarts right after done.
        run_frame(1'b0, 1'b1, -1, 0);
        run_frame(1'b0, 1'b0, -1, 0);
        start = 1'b0;
        @(negedge clk);
        chk("after_frames_idle", busy, 0);

        // Abort mid-frame in RD_D2 of pixel (1,2).
        for (int a = 0; a < N; a++) begin
            img[a] = 8'($urandom);
            wmm[a] = 2'($urandom);
        end
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0;
        end while (!(out_valid && out_row == 8'd1 && out_col == 8'd1) && n < 100);
        chk("abort_reach", {out_row, out_col}, {8'd1, 8'd1});
        @(negedge clk);
        @(negedge clk);
        chk("abort_rd_d2", {busy, pix_rd}, 2'b11);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1 chk_zero("async_reset");
        repeat (3) begin
            @(negedge clk);
            chk_zero("held_reset");
        end
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("post_reset_idle");
        chk("no_done_on_abort", done_cnt - d0, 0);
        run_frame(1'b0, 1'b0, -1, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
